mem_crc_ctrl: RTL and testbench
===============================

# mem_crc_ctrl

Access controller that acts as the initiator for the 8x4 RAM in the mem_access design. It writes a 7-nibble data block plus a CRC-4 check nibble into the RAM, reads the block back, and verifies the CRC. It also supports a single-nibble poke for diagnostics and fault injection. The block sits between the host/test logic and the RAM port (address, data_in, write_enable, read_enable, data_out).

## Interface
Parameters:
- CRC_POLY, 4'b0011, low bits of the generator polynomial x^4+x+1.
- CRC_INIT, 4'b0000, CRC seed at the start of each block.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  operation request; sampled only in IDLE
- op  in  2  operation code: 00 = write block, 01 = read and verify, 10 = poke, 11 = reserved (treated as no-op, completes with done)
- wr_block  in  28  block data; nibble k = wr_block[4k+3:4k] goes to RAM address k (k = 0..6)
- poke_addr  in  3  poke address
- poke_data  in  4  poke data
- busy  out  1  high from the cycle after start is accepted until done is asserted
- done  out  1  one-cycle completion pulse
- rd_block  out  28  nibbles 0..6 read back; updated only by a read op
- rd_crc  out  4  nibble read from address 7
- crc_ok  out  1  valid at done of a read op; holds its value until the next read op completes
- ram_address  out  3  to RAM address
- ram_data  out  4  to RAM data_in
- ram_we  out  1  to RAM write_enable
- ram_re  out  1  to RAM read_enable
- ram_q  in  4  from RAM data_out; valid in the same cycle as ram_re and ram_address (combinational read)

## Operation
- States:
  - IDLE: start=1 → WR, RD or POKE by op; op=11 → DONE.
  - WR: counter 0..7, ram_we=1, ram_address=counter. Counters 0..6 write nibble[counter] and fold it into the running CRC. Counter 7 writes the final CRC.
  - RD: counter 0..7, ram_re=1, ram_address=counter. ram_q is captured at each edge. Counters 0..6 fill rd_block and fold into the CRC; counter 7 fills rd_crc. Then → CMP.
  - CMP: crc_ok = (computed CRC == rd_crc).
  - POKE: one cycle with ram_we=1, ram_address=poke_addr, ram_data=poke_data. Then → DONE.
  - DONE: done=1 → IDLE.
- CRC-4 update per nibble, bits MSB first: fb = crc[3] ^ bit; crc = {crc[2:0],1'b0} ^ (fb ? CRC_POLY : 0). The CRC is seeded with CRC_INIT on entry to WR or RD.
- When ram_we=0, ram_data=0. ram_we and ram_re are never high together.
- start while busy is ignored, with no queueing.
- wr_block is captured into an internal register when start is accepted. Later changes to wr_block do not affect an operation in progress.
- Reset values: busy=0, done=0, crc_ok=0, rd_block=0, rd_crc=0, ram_address=0, ram_data=0, ram_we=0, ram_re=0, state=IDLE, counter=0.
- Reset mid-operation aborts immediately with no done pulse. RAM contents follow the RAM's own reset.

## Timing
- start is sampled at edge E0.
- Write block: ram_we is high in the 8 cycles after E0; RAM writes occur at edges E1..E8. done is high in the cycle after E8. busy is low and the block is ready for a new start in the cycle after done.
- Read/verify: ram_re is high in the 8 cycles after E0; ram_q is captured at E1..E8. CMP is the cycle after E8, then done. crc_ok and rd_block are stable in the done cycle.
- Poke: ram_we is high in 1 cycle (write at E1); done is high in the cycle after E1.
- Reserved op: done is high in the cycle after E0.
- Back-to-back: a start asserted in the done cycle is ignored. The next start is accepted in IDLE.

## Structure
- Shared include header mem_access_defs.vh holds:
  - op codes (OP_WRITE, OP_READ, OP_POKE)
  - state encodings
  - CRC_POLY and CRC_INIT defaults
  - RAM geometry constants (depth 8, width 4)
- Sub-module crc4_nibble: combinational, with inputs crc_in[3:0] and nibble[3:0] and output crc_out[3:0]. It is shared by the WR and RD paths.
- The controller is a single FSM with a 3-bit counter.

## Test plan
- Reset during WR at counter 3 → all outputs return to their reset values immediately. There is no done pulse. The next op after reset is deasserted runs normally.
- Write wr_block=28'h0000000, then read → RAM address 7 = 4'h0, rd_crc=0, crc_ok=1, done exactly 9 and 10 cycles after the respective starts.
- Write wr_block=28'h0000001, then read → stored CRC = 4'hD, rd_block=28'h0000001, crc_ok=1.
- Write wr_block=28'h0000001, poke addr 3 data 4'hF, then read → rd_block=28'h000F001, rd_crc=4'hD, crc_ok=0.
- start pulsed repeatedly while busy, and op=11 in IDLE → extra starts are ignored (exactly one write sequence and one done). op=11 gives done one cycle after start, with no RAM strobes.
- Protocol checker throughout every scenario → ram_we and ram_re are never both 1. When ram_we=0, ram_data=0. Each read leaves ram_re high for exactly 8 consecutive cycles over addresses 0..7.

Source files
------------

// File: rtl/mem_crc_ctrl_pkg.sv
// ============================================================================
// mem_crc_ctrl_pkg : shared op codes, FSM states and RAM/CRC geometry
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_crc_ctrl_pkg;

    localparam int RAM_DEPTH     = 8;
    localparam int RAM_W         = 4;
    localparam int ADDR_W        = 3;
    localparam int BLOCK_NIBBLES = 7;
    localparam int BLOCK_W       = BLOCK_NIBBLES * RAM_W;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_NIB  = ADDR_W'(BLOCK_NIBBLES - 1);

    localparam logic [RAM_W-1:0] CRC_POLY_DEF = 4'b0011;
    localparam logic [RAM_W-1:0] CRC_INIT_DEF = 4'b0000;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_POKE  = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_CMP  = 3'd3,
        ST_POKE = 3'd4,
        ST_DONE = 3'd5
    } state_e;

endpackage

`default_nettype wire

// File: rtl/crc4_nibble.sv
// ============================================================================
// crc4_nibble : folds one nibble (MSB first) into a running CRC-4
// Revision: 1.0
// ============================================================================
`default_nettype none

module crc4_nibble
    import mem_crc_ctrl_pkg::*;
#(
    parameter logic [RAM_W-1:0] CRC_POLY = CRC_POLY_DEF
) (
    input  logic [RAM_W-1:0] crc_in_i,
    input  logic [RAM_W-1:0] nibble_i,
    output logic [RAM_W-1:0] crc_out_o
);

    function automatic logic [RAM_W-1:0] fold(input logic [RAM_W-1:0] c,
                                              input logic [RAM_W-1:0] n);
        logic [RAM_W-1:0] r;
        r = c;
        for (int i = RAM_W - 1; i >= 0; i--) begin
            r = {r[RAM_W-2:0], 1'b0} ^ ((r[RAM_W-1] ^ n[i]) ? CRC_POLY : '0);
        end
        return r;
    endfunction

    assign crc_out_o = fold(crc_in_i, nibble_i);

endmodule

`default_nettype wire

// File: rtl/mem_crc_ctrl.sv
// ============================================================================
// mem_crc_ctrl : writes/reads a 7-nibble block plus CRC-4 to an 8x4 RAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_crc_ctrl
    import mem_crc_ctrl_pkg::*;
#(
    parameter logic [RAM_W-1:0] CRC_POLY = CRC_POLY_DEF,
    parameter logic [RAM_W-1:0] CRC_INIT = CRC_INIT_DEF
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [1:0]          op_i,
    input  logic [BLOCK_W-1:0]  wr_block_i,
    input  logic [ADDR_W-1:0]   poke_addr_i,
    input  logic [RAM_W-1:0]    poke_data_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [BLOCK_W-1:0]  rd_block_o,
    output logic [RAM_W-1:0]    rd_crc_o,
    output logic                crc_ok_o,
    output logic [ADDR_W-1:0]   ram_address_o,
    output logic [RAM_W-1:0]    ram_data_o,
    output logic                ram_we_o,
    output logic                ram_re_o,
    input  logic [RAM_W-1:0]    ram_q_i
);

    state_e                      state_q;
    logic [ADDR_W-1:0]           cnt_q;
    logic [RAM_W-1:0]            crc_q;
    logic [BLOCK_W-RAM_W-1:0]    blk_q;
    logic                        busy_q, done_q, crc_ok_q, we_q, re_q;
    logic [BLOCK_W-1:0]          rd_block_q;
    logic [RAM_W-1:0]            rd_crc_q, data_q;
    logic [ADDR_W-1:0]           addr_q;

    logic [ADDR_W-1:0]           cnt_d;
    logic [RAM_W-1:0]            nib_d, crc_d;

    // Writes fold the nibble being driven; reads fold the nibble coming back.
    assign nib_d = (state_q == ST_RD) ? ram_q_i : data_q;
    assign cnt_d = cnt_q + 3'd1;

    crc4_nibble #(.CRC_POLY(CRC_POLY)) u_crc (
        .crc_in_i (crc_q),
        .nibble_i (nib_d),
        .crc_out_o(crc_d)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            crc_q      <= '0;
            blk_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crc_ok_q   <= 1'b0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            rd_block_q <= '0;
            rd_crc_q   <= '0;
            data_q     <= '0;
            addr_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        blk_q  <= wr_block_i[BLOCK_W-1:RAM_W];
                        crc_q  <= CRC_INIT;
                        cnt_q  <= '0;
                        addr_q <= '0;
                        case (op_i)
                            OP_WRITE: begin
                                state_q <= ST_WR;
                                busy_q  <= 1'b1;
                                we_q    <= 1'b1;
                                data_q  <= wr_block_i[RAM_W-1:0];
                            end
                            OP_READ: begin
                                state_q <= ST_RD;
                                busy_q  <= 1'b1;
                                re_q    <= 1'b1;
                            end
                            OP_POKE: begin
                                state_q <= ST_POKE;
                                busy_q  <= 1'b1;
                                we_q    <= 1'b1;
                                addr_q  <= poke_addr_i;
                                data_q  <= poke_data_i;
                            end
                            default: begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_WR: begin
                    crc_q <= crc_d;
                    blk_q <= blk_q >> RAM_W;
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= ST_DONE;
                        cnt_q   <= '0;
                        addr_q  <= '0;
                        data_q  <= '0;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_d;
                        addr_q <= cnt_d;
                        // After the last data nibble the check nibble goes to address 7.
                        data_q <= (cnt_q == LAST_NIB) ? crc_d : blk_q[RAM_W-1:0];
                    end
                end
                ST_RD: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q  <= ST_CMP;
                        rd_crc_q <= ram_q_i;
                        cnt_q    <= '0;
                        addr_q   <= '0;
                        re_q     <= 1'b0;
                    end else begin
                        rd_block_q <= {ram_q_i, rd_block_q[BLOCK_W-1:RAM_W]};
                        crc_q      <= crc_d;
                        cnt_q      <= cnt_d;
                        addr_q     <= cnt_d;
                    end
                end
                ST_CMP: begin
                    state_q  <= ST_DONE;
                    crc_ok_q <= (crc_q == rd_crc_q);
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end
                ST_POKE: begin
                    state_q <= ST_DONE;
                    addr_q  <= '0;
                    data_q  <= '0;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign rd_block_o    = rd_block_q;
    assign rd_crc_o      = rd_crc_q;
    assign crc_ok_o      = crc_ok_q;
    assign ram_address_o = addr_q;
    assign ram_data_o    = data_q;
    assign ram_we_o      = we_q;
    assign ram_re_o      = re_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_crc_ctrl.sv
// ============================================================================
// tb_mem_crc_ctrl : scoreboard bench with a RAM model and a CRC reference
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_crc_ctrl;

    localparam logic [1:0] OPW = 2'b00;
    localparam logic [1:0] OPR = 2'b01;
    localparam logic [1:0] OPP = 2'b10;
    localparam logic [1:0] OPN = 2'b11;

    logic        clk, reset, start;
    logic [1:0]  op;
    logic [27:0] wr_block;
    logic [2:0]  poke_addr;
    logic [3:0]  poke_data;
    logic        busy, done, crc_ok, ram_we, ram_re;
    logic [27:0] rd_block;
    logic [3:0]  rd_crc, ram_data, ram_q;
    logic [2:0]  ram_address;

    mem_crc_ctrl dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .op_i         (op),
        .wr_block_i   (wr_block),
        .poke_addr_i  (poke_addr),
        .poke_data_i  (poke_data),
        .busy_o       (busy),
        .done_o       (done),
        .rd_block_o   (rd_block),
        .rd_crc_o     (rd_crc),
        .crc_ok_o     (crc_ok),
        .ram_address_o(ram_address),
        .ram_data_o   (ram_data),
        .ram_we_o     (ram_we),
        .ram_re_o     (ram_re),
        .ram_q_i      (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8x4 RAM with combinational read and its own reset.
    logic [3:0] mem [0:7];
    assign ram_q = mem[ram_address];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) mem[i] <= 4'h0;
        end else if (ram_we) begin
            mem[ram_address] <= ram_data;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // CRC as the remainder of (message * x^4) mod x^4+x+1, message sent nibble 0 first, MSB first.
    function automatic logic [3:0] model_crc(input logic [27:0] blk);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 7; k++) m = (m << 4) | 32'(blk[4*k +: 4]);
        m = m << 4;
        for (int b = 31; b >= 4; b--) if (m[b]) m = m ^ (32'h13 << (b - 4));
        return m[3:0];
    endfunction

    typedef struct {
        int          issue;
        int          lat;
        int          we;
        logic [27:0] blk;
        logic [3:0]  crc;
        logic        ok;
    } exp_t;

    exp_t        q[$];
    logic [3:0]  exp_mem [0:7];
    logic [27:0] last_blk;
    logic [3:0]  last_crc;
    logic        last_ok;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) exp_mem[i] = 4'h0;
        last_blk = '0;
        last_crc = '0;
        last_ok  = 1'b0;
    endtask

    task automatic push_expect(input logic [1:0] o, input logic [27:0] blk,
                               input logic [2:0] pa, input logic [3:0] pd);
        exp_t e;
        e.issue = cyc + 1;
        case (o)
            OPW: begin
                for (int k = 0; k < 7; k++) exp_mem[k] = blk[4*k +: 4];
                exp_mem[7] = model_crc(blk);
                e.lat = 8; e.we = 8;
            end
            OPR: begin
                for (int k = 0; k < 7; k++) last_blk[4*k +: 4] = exp_mem[k];
                last_crc = exp_mem[7];
                last_ok  = (model_crc(last_blk) == last_crc);
                e.lat = 9; e.we = 0;
            end
            OPP: begin
                exp_mem[pa] = pd;
                e.lat = 1; e.we = 1;
            end
            default: begin
                e.lat = 0; e.we = 0;
            end
        endcase
        e.blk = last_blk;
        e.crc = last_crc;
        e.ok  = last_ok;
        q.push_back(e);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after done.
    task automatic do_op(input logic [1:0] o, input logic [27:0] blk,
                         input logic [2:0] pa, input logic [3:0] pd, input bit hammer);
        int w;
        push_expect(o, blk, pa, pd);
        start = 1'b1; op = o; wr_block = blk; poke_addr = pa; poke_data = pd;
        @(negedge clk);
        start = 1'b0;
        wr_block = 28'($urandom()); poke_addr = 3'($urandom()); poke_data = 4'($urandom());
        chk("busy_after_start", busy, (o != OPN));
        if (hammer) begin
            for (int i = 0; i < 5; i++) begin
                start = 1'b1; op = 2'($urandom());
                @(negedge clk);
            end
            start = 1'b0;
        end
        w = 0;
        while (!done && w < 30) begin
            @(negedge clk);
            w++;
        end
        if (!done) chk("done_timeout", done, 1);
        @(negedge clk);
    endtask

    task automatic rand_op();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4)       do_op(OPW, 28'($urandom()), 3'd0, 4'd0, 1'b0);
        else if (r < 7)  do_op(OPR, 28'($urandom()), 3'($urandom()), 4'($urandom()), 1'b0);
        else if (r < 9)  do_op(OPP, 28'($urandom()), 3'($urandom()), 4'($urandom()), 1'b0);
        else             do_op(OPN, 28'($urandom()), 3'd0, 4'd0, 1'b0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_crc_ok"}, crc_ok, 0);
        chk({tag, "_rd_block"}, rd_block, 0);
        chk({tag, "_rd_crc"}, rd_crc, 0);
        chk({tag, "_ram_address"}, ram_address, 0);
        chk({tag, "_ram_data"}, ram_data, 0);
        chk({tag, "_ram_we"}, ram_we, 0);
        chk({tag, "_ram_re"}, ram_re, 0);
    endtask

    // Monitor: protocol rules every cycle, scoreboard pop on every done.
    exp_t m_e;
    int   we_cnt = 0;
    int   re_run = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                we_cnt = 0;
                re_run = 0;
            end else begin
                chk("we_re_exclusive", ram_we & ram_re, 0);
                if (!ram_we) chk("data_zero_without_we", ram_data, 0);
                if (ram_re) begin
                    chk("re_addr_seq", ram_address, re_run);
                    re_run++;
                end else if (re_run != 0) begin
                    chk("re_burst_len", re_run, 8);
                    re_run = 0;
                end
                if (ram_we) we_cnt++;
                if (done) begin
                    if (q.size() == 0) begin
                        chk("spurious_done", done, 0);
                    end else begin
                        m_e = q.pop_front();
                        chk("done_latency", cyc - m_e.issue, m_e.lat);
                        chk("we_cycles", we_cnt, m_e.we);
                        chk("busy_in_done", busy, 0);
                        chk("rd_block", rd_block, m_e.blk);
                        chk("rd_crc", rd_crc, m_e.crc);
                        chk("crc_ok", crc_ok, m_e.ok);
                    end
                    we_cnt = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset = 1'b1; start = 1'b0; op = OPW; wr_block = '0; poke_addr = '0; poke_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_outputs("por");

        do_op(OPW, 28'h0000000, 3'd0, 4'd0, 1'b0);
        do_op(OPR, 28'h0000000, 3'd0, 4'd0, 1'b0);
        do_op(OPW, 28'h0000001, 3'd0, 4'd0, 1'b0);
        do_op(OPR, 28'h0000000, 3'd0, 4'd0, 1'b0);
        do_op(OPW, 28'h0000001, 3'd0, 4'd0, 1'b0);
        do_op(OPP, 28'h0000000, 3'd3, 4'hF, 1'b0);
        do_op(OPR, 28'h0000000, 3'd0, 4'd0, 1'b0);

        // Starts while busy must be ignored; a restart would show up as a spurious done.
        do_op(OPW, 28'($urandom()), 3'd0, 4'd0, 1'b1);
        repeat (12) @(negedge clk);
        do_op(OPN, 28'($urandom()), 3'd0, 4'd0, 1'b0);
        do_op(OPR, 28'h0000000, 3'd0, 4'd0, 1'b0);

        // Asynchronous reset in the middle of a block write.
        start = 1'b1; op = OPW; wr_block = 28'($urandom());
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!(ram_we && ram_address == 3'd3) && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("reach_wr_cnt3", ram_address, 3);
        reset = 1'b1;
        #1;
        chk_reset_outputs("mid_reset");
        q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        do_op(OPW, 28'($urandom()), 3'd0, 4'd0, 1'b0);
        do_op(OPR, 28'h0000000, 3'd0, 4'd0, 1'b0);

        for (int i = 0; i < 40; i++) rand_op();
        do_op(OPR, 28'h0000000, 3'd0, 4'd0, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
